nn_argmax_classifier: RTL

Downstream stage of the two-layer network. It captures the 10 signed output-layer scores and scans them sequentially, one per cycle. It reports the winning class index and its score through a valid/ready handshake. The winning index is the digit decision fed to the display and host readout logic.

---
 rtl/nn_pkg.sv | 16 +
 rtl/argmax_cmp_step.sv | 42 ++++
 rtl/nn_argmax_classifier.sv | 126 ++++++++++++
 3 files changed

// File: rtl/nn_pkg.sv
// Shared types and defaults for the network's output stage.
// Used by nn_argmax_classifier and argmax_cmp_step.
package nn_pkg;

  localparam int N_CLASSES_DEF = 10;
  localparam int SCORE_W_DEF   = 64;

  typedef logic signed [SCORE_W_DEF-1:0] score_t;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    HOLD
  } argmax_state_t;

endpackage

// File: rtl/argmax_cmp_step.sv
// One combinational step of the argmax scan: folds one candidate into the running best.
// With ARGMAX_MARGIN_EN defined it also tracks the runner-up score.
module argmax_cmp_step
  import nn_pkg::*;
#(
  parameter int SCORE_W = SCORE_W_DEF,
  parameter int IDX_W   = 4
) (
  input  logic signed [SCORE_W-1:0] best,
  input  logic        [IDX_W-1:0]   best_idx,
  input  logic signed [SCORE_W-1:0] candidate,
  input  logic        [IDX_W-1:0]   cand_idx,
`ifdef ARGMAX_MARGIN_EN
  input  logic signed [SCORE_W-1:0] second_best,
  output logic signed [SCORE_W-1:0] next_second_best,
`endif
  output logic signed [SCORE_W-1:0] next_best,
  output logic        [IDX_W-1:0]   next_best_idx
);

  // Strict compare so a tie keeps the earlier (lower) index.
  always_comb begin
    next_best     = best;
    next_best_idx = best_idx;
`ifdef ARGMAX_MARGIN_EN
    next_second_best = second_best;
`endif
    if (candidate > best) begin
      next_best     = candidate;
      next_best_idx = cand_idx;
`ifdef ARGMAX_MARGIN_EN
      next_second_best = best;
`endif
    end
`ifdef ARGMAX_MARGIN_EN
    else if (candidate > second_best) begin
      next_second_best = candidate;
    end
`endif
  end

endmodule

// File: rtl/nn_argmax_classifier.sv
// Captures the output-layer scores and scans them one per cycle to find the winning class.
// Optional margin output (best minus runner-up) is enabled with ARGMAX_MARGIN_EN.
module nn_argmax_classifier
  import nn_pkg::*;
#(
  parameter int N_CLASSES = N_CLASSES_DEF,
  parameter int SCORE_W   = SCORE_W_DEF,
  parameter int IDX_W     = 4
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [N_CLASSES-1:0][SCORE_W-1:0]   scores_in,
  input  logic                                in_valid,
  output logic                                in_ready,
  output logic [IDX_W-1:0]                    class_idx,
  output logic [SCORE_W-1:0]                  max_score,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic                                busy
`ifdef ARGMAX_MARGIN_EN
  ,
  output logic [SCORE_W:0]                    margin
`endif
);

  localparam logic [SCORE_W-1:0] SCORE_MIN = {1'b1, {(SCORE_W-1){1'b0}}};
  localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(N_CLASSES - 1);

  argmax_state_t state, state_next;

  logic [N_CLASSES-1:0][SCORE_W-1:0] scores_q;
  logic signed [SCORE_W-1:0]         best, step_best;
  logic [IDX_W-1:0]                  best_idx, step_best_idx, i;

`ifdef ARGMAX_MARGIN_EN
  logic signed [SCORE_W-1:0] second_best, step_second_best;
  logic        [SCORE_W:0]   margin_diff;
`endif

  argmax_cmp_step #(
    .SCORE_W(SCORE_W),
    .IDX_W  (IDX_W)
  ) u_step (
    .best            (best),
    .best_idx        (best_idx),
    .candidate       ($signed(scores_q[i])),
    .cand_idx        (i),
`ifdef ARGMAX_MARGIN_EN
    .second_best     (second_best),
    .next_second_best(step_second_best),
`endif
    .next_best       (step_best),
    .next_best_idx   (step_best_idx)
  );

  // Datapath: capture on acceptance, fold one score per SCAN cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      best     <= '0;
      best_idx <= '0;
      i        <= '0;
`ifdef ARGMAX_MARGIN_EN
      second_best <= '0;
`endif
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (in_valid) begin
            scores_q <= scores_in;
            best     <= $signed(scores_in[0]);
            best_idx <= '0;
            i        <= IDX_W'(1);
`ifdef ARGMAX_MARGIN_EN
            second_best <= $signed(SCORE_MIN);
`endif
          end
        end
        SCAN: begin
          best     <= step_best;
          best_idx <= step_best_idx;
          i        <= i + IDX_W'(1);
`ifdef ARGMAX_MARGIN_EN
          second_best <= step_second_best;
`endif
        end
        default: ;
      endcase
    end
  end

  // Next state and state-decoded handshake outputs.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = (N_CLASSES == 1) ? HOLD : SCAN;
      end
      SCAN: begin
        busy = 1'b1;
        if (i == LAST_IDX) state_next = HOLD;
      end
      HOLD: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign class_idx = best_idx;
  assign max_score = best;

`ifdef ARGMAX_MARGIN_EN
  // best never drops below second_best, so the widened difference is non-negative.
  assign margin_diff = {best[SCORE_W-1], best} - {second_best[SCORE_W-1], second_best};
  assign margin = (N_CLASSES == 1) ? (out_valid ? {(SCORE_W+1){1'b1}} : '0) : margin_diff;
`endif

endmodule
